// File: rtl/instr_decoder_seq_pkg.sv
// ---------------------------------------------------------------------------
// decoder_pkg
// Shared definitions for the instruction decoder and its watchdog:
//   - opcode values (ADD..STORE)
//   - execution class enum and the opcode -> class mapping
//   - decoder FSM state enum
// Optional build macro affecting users of this package: DECODER_SIGN_EXT_IMM_EN
// (selects sign- vs zero-extension of the immediate in instr_decoder_seq).
// ---------------------------------------------------------------------------
package decoder_pkg;

  localparam int unsigned OP_ADD   = 0;
  localparam int unsigned OP_SUB   = 1;
  localparam int unsigned OP_NOT   = 2;
  localparam int unsigned OP_AND   = 3;
  localparam int unsigned OP_OR    = 4;
  localparam int unsigned OP_XOR   = 5;
  localparam int unsigned OP_XNOR  = 6;
  localparam int unsigned OP_ADDI  = 7;
  localparam int unsigned OP_SUBI  = 8;
  localparam int unsigned OP_MOVI  = 9;
  localparam int unsigned OP_MOV   = 10;
  localparam int unsigned OP_LOAD  = 11;
  localparam int unsigned OP_STORE = 12;

  typedef enum logic [1:0] {
    CLS_ALU,
    CLS_MOV,
    CLS_LDST,
    CLS_ILLEGAL
  } cls_e;

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    ISSUE
  } state_e;

  // Opcode is passed zero-extended so the mapping is independent of OPC_W;
  // anything outside the defined set (13 and up) is illegal.
  function automatic cls_e opcode_class(input logic [31:0] opc);
    cls_e cls;
    case (opc)
      OP_ADD, OP_SUB, OP_NOT, OP_AND, OP_OR,
      OP_XOR, OP_XNOR, OP_ADDI, OP_SUBI: cls = CLS_ALU;
      OP_MOVI, OP_MOV:                   cls = CLS_MOV;
      OP_LOAD, OP_STORE:                 cls = CLS_LDST;
      default:                           cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/instr_decoder_seq_if.sv
// ---------------------------------------------------------------------------
// instr_decoder_seq_if
// Groups the fetch-side, execution-side and register-file-index signals of
// the instruction decoder.
//   master : fetch/execution side (drives flush, ir_load, instr, sel_i,
//            sel_j, imm_oe, exec_done; observes decoder outputs)
//   slave  : the decoder itself
// ---------------------------------------------------------------------------
interface instr_decoder_seq_if #(
  parameter int INSTR_W = 16,
  parameter int OPC_W   = 4,
  parameter int IDX_W   = 6,
  parameter int BUS_W   = 16
);

  logic               flush;
  logic               ir_load;
  logic [INSTR_W-1:0] instr;
  logic               ready;
  logic               sel_i;
  logic               sel_j;
  logic               imm_oe;
  logic               exec_done;
  logic [OPC_W-1:0]   opcode;
  logic [IDX_W-1:0]   index;
  logic               alu_str;
  logic               mov_str;
  logic               ldst_str;
  logic [BUS_W-1:0]   imm_out;
  logic               bus_oe;
  logic               illegal;
  logic               timeout;

  modport master (
    output flush, ir_load, instr, sel_i, sel_j, imm_oe, exec_done,
    input  ready, opcode, index, alu_str, mov_str, ldst_str,
           imm_out, bus_oe, illegal, timeout
  );

  modport slave (
    input  flush, ir_load, instr, sel_i, sel_j, imm_oe, exec_done,
    output ready, opcode, index, alu_str, mov_str, ldst_str,
           imm_out, bus_oe, illegal, timeout
  );

endinterface

// File: rtl/instr_decoder_seq_watchdog.sv
// ---------------------------------------------------------------------------
// decoder_watchdog
// Counts cycles while enabled and flags expiry on the TIMEOUT-th enabled
// cycle. TIMEOUT = 0 disables expiry entirely.
// Ports:
//   clk      clock, rising edge
//   reset    asynchronous, active-high
//   clr_i    synchronous clear (dominates en_i)
//   en_i     count enable (unit busy)
//   expire_o combinational: high during the TIMEOUT-th enabled cycle
// ---------------------------------------------------------------------------
module decoder_watchdog #(
  parameter int unsigned TIMEOUT = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  // Count value seen during the last allowed cycle.
  localparam logic [CNT_W-1:0] TC = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != TC)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expire_o = (TIMEOUT != 0) && en_i && (cnt_q == TC);

endmodule

// File: rtl/instr_decoder_seq.sv
// ---------------------------------------------------------------------------
// instr_decoder_seq
// Latches an instruction on ir_load, classifies its opcode and holds a level
// start strobe to the ALU / MOV / LOAD-STORE unit until exec_done (or a
// watchdog abort). Also provides a registered operand index, an extended
// immediate for bus drive and illegal-opcode detection.
//
// Build macro: DECODER_SIGN_EXT_IMM_EN -- when defined imm_out is the
// immediate sign-extended from bit IMM_W-1, otherwise zero-extended.
//
// Ports:
//   clk    clock, rising edge
//   reset  asynchronous, active-high
//   dec    instr_decoder_seq_if.slave:
//     in : flush, ir_load, instr, sel_i, sel_j, imm_oe, exec_done
//     out: ready, opcode, index, alu_str, mov_str, ldst_str,
//          imm_out, bus_oe (enable for an external tri-state), illegal,
//          timeout
//
// state  | meaning
// IDLE   | waiting for ir_load; ready high
// DECODE | one cycle: classify ir_q, raise one strobe or drop illegal
// ISSUE  | strobe held until exec_done or watchdog expiry
// ---------------------------------------------------------------------------
module instr_decoder_seq
  import decoder_pkg::*;
#(
  parameter int          INSTR_W = 16,
  parameter int          OPC_W   = 4,
  parameter int          IDX_W   = 6,
  parameter int          IMM_W   = 6,
  parameter int          BUS_W   = 16,
  parameter int unsigned TIMEOUT = 0
) (
  input logic               clk,
  input logic               reset,
  instr_decoder_seq_if.slave dec
);

  if ((OPC_W + 2 * IDX_W > INSTR_W) || (IMM_W > BUS_W)) begin : g_param_check
    $error("instr_decoder_seq: field widths do not fit INSTR_W/BUS_W");
  end

  state_e             state_q;
  logic [INSTR_W-1:0] ir_q;
  logic [IDX_W-1:0]   index_q;
  logic [IDX_W-1:0]   index_d;
  logic               alu_q;
  logic               mov_q;
  logic               ldst_q;
  logic               illegal_q;
  logic               timeout_q;
  logic [BUS_W-1:0]   imm_ext;
  logic [IMM_W-1:0]   imm;
  cls_e               load_cls;
  cls_e               dec_cls;
  logic               wd_expire;

  assign load_cls = opcode_class(32'(dec.instr[INSTR_W-1 -: OPC_W]));
  assign dec_cls  = opcode_class(32'(ir_q[INSTR_W-1 -: OPC_W]));

  decoder_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (dec.flush || (state_q != ISSUE)),
    .en_i     (state_q == ISSUE),
    .expire_o (wd_expire)
  );

  // illegal is registered at the load edge so its single-cycle pulse lines
  // up with the DECODE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ir_q      <= '0;
      alu_q     <= 1'b0;
      mov_q     <= 1'b0;
      ldst_q    <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      if (dec.flush) begin
        state_q <= IDLE;
        alu_q   <= 1'b0;
        mov_q   <= 1'b0;
        ldst_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (dec.ir_load) begin
              ir_q      <= dec.instr;
              illegal_q <= (load_cls == CLS_ILLEGAL);
              state_q   <= DECODE;
            end
          end
          DECODE: begin
            case (dec_cls)
              CLS_ALU: begin
                alu_q   <= 1'b1;
                state_q <= ISSUE;
              end
              CLS_MOV: begin
                mov_q   <= 1'b1;
                state_q <= ISSUE;
              end
              CLS_LDST: begin
                ldst_q  <= 1'b1;
                state_q <= ISSUE;
              end
              default: state_q <= IDLE;
            endcase
          end
          ISSUE: begin
            // Completion in the expiry cycle wins over the abort.
            if (dec.exec_done) begin
              alu_q   <= 1'b0;
              mov_q   <= 1'b0;
              ldst_q  <= 1'b0;
              state_q <= IDLE;
            end else if (wd_expire) begin
              alu_q     <= 1'b0;
              mov_q     <= 1'b0;
              ldst_q    <= 1'b0;
              timeout_q <= 1'b1;
              state_q   <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Index selection reads the latched instruction, never the live bus.
  always_comb begin
    index_d = index_q;
    if (dec.flush) begin
      index_d = '0;
    end else if (dec.sel_i) begin
      index_d = ir_q[INSTR_W-OPC_W-1 -: IDX_W];
    end else if (dec.sel_j) begin
      index_d = ir_q[IDX_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      index_q <= '0;
    end else begin
      index_q <= index_d;
    end
  end

  assign imm = ir_q[IMM_W-1:0];

  always_comb begin
    imm_ext = '0;
    imm_ext[IMM_W-1:0] = imm;
`ifdef DECODER_SIGN_EXT_IMM_EN
    for (int b = IMM_W; b < BUS_W; b++) begin
      imm_ext[b] = imm[IMM_W-1];
    end
`endif
  end

  assign dec.ready    = (state_q == IDLE);
  assign dec.opcode   = ir_q[INSTR_W-1 -: OPC_W];
  assign dec.index    = index_q;
  assign dec.alu_str  = alu_q;
  assign dec.mov_str  = mov_q;
  assign dec.ldst_str = ldst_q;
  assign dec.imm_out  = imm_ext;
  assign dec.bus_oe   = dec.imm_oe && (state_q == ISSUE);
  assign dec.illegal  = illegal_q;
  assign dec.timeout  = timeout_q;

endmodule

// File: tb/tb_instr_decoder_seq.sv
// ---------------------------------------------------------------------------
// tb_instr_decoder_seq
// Directed and randomized stimulus for instr_decoder_seq (TIMEOUT = 8),
// checked against a behavioural model of the decoder's instruction rules.
// ---------------------------------------------------------------------------
module tb_instr_decoder_seq;

  localparam int TMO = 8;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [15:0] cur_ir;   // model: last accepted instruction
  logic [5:0]  exp_idx;  // model: expected index register

  instr_decoder_seq_if #(.INSTR_W(16), .OPC_W(4), .IDX_W(6), .BUS_W(16)) dif ();

  instr_decoder_seq #(
    .INSTR_W(16), .OPC_W(4), .IDX_W(6), .IMM_W(6), .BUS_W(16), .TIMEOUT(TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .dec   (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 0 = ALU, 1 = MOV, 2 = LDST, 3 = illegal
  function automatic int ref_class(input logic [15:0] ins);
    int op;
    op = int'(ins >> 12);
    if (op <= 8)  return 0;
    if (op <= 10) return 1;
    if (op <= 12) return 2;
    return 3;
  endfunction

  function automatic logic [15:0] ref_imm(input logic [15:0] ins);
    int v;
    v = int'(ins) % 64;
`ifdef DECODER_SIGN_EXT_IMM_EN
    if (v >= 32) v = v - 64;
`endif
    return 16'(v);
  endfunction

  function automatic logic [2:0] strobes();
    return {dif.alu_str, dif.mov_str, dif.ldst_str};
  endfunction

  // Issue one instruction from IDLE; exec_done in ISSUE cycle done_at
  // (values past TMO mean the unit never answers).
  task automatic do_instr(input logic [15:0] ins, input int done_at, input logic oe);
    int       cls;
    logic [2:0] exp_str;
    cls         = ref_class(ins);
    exp_str     = 3'b100 >> cls;
    dif.ir_load = 1'b1;
    dif.instr   = ins;
    tick();
    dif.ir_load = 1'b0;
    dif.instr   = 16'($urandom);
    dif.imm_oe  = oe;
    cur_ir      = ins;
    check("dec_ready", dif.ready, 0);
    check("dec_illegal", dif.illegal, (cls == 3) ? 1 : 0);
    check("dec_opcode", dif.opcode, 32'(ins >> 12));
    check("dec_strobes", strobes(), 0);
    check("dec_bus_oe", dif.bus_oe, 0);
    tick();
    if (cls == 3) begin
      check("ill_ready", dif.ready, 1);
      check("ill_pulse_end", dif.illegal, 0);
      check("ill_strobes", strobes(), 0);
      return;
    end
    for (int k = 1; k <= TMO; k++) begin
      check("iss_strobes", strobes(), exp_str);
      check("iss_ready", dif.ready, 0);
      check("iss_timeout", dif.timeout, 0);
      check("iss_bus_oe", dif.bus_oe, oe);
      check("iss_imm", dif.imm_out, ref_imm(ins));
      check("iss_index", dif.index, exp_idx);
      dif.exec_done = (k == done_at);
      tick();
      dif.exec_done = 1'b0;
      if (k == done_at) begin
        check("done_strobes", strobes(), 0);
        check("done_ready", dif.ready, 1);
        check("done_timeout", dif.timeout, 0);
        return;
      end
      if (k == TMO) begin
        check("tmo_pulse", dif.timeout, 1);
        check("tmo_strobes", strobes(), 0);
        check("tmo_ready", dif.ready, 1);
      end
    end
    dif.imm_oe = 1'b0;
  endtask

  task automatic sel_step(input logic si, input logic sj);
    dif.sel_i = si;
    dif.sel_j = sj;
    tick();
    dif.sel_i = 1'b0;
    dif.sel_j = 1'b0;
    if (si)      exp_idx = 6'((cur_ir >> 6) % 64);
    else if (sj) exp_idx = 6'(cur_ir % 64);
    check("sel_index", dif.index, exp_idx);
  endtask

  initial begin
    logic [15:0] rins;
    checks        = 0;
    errors        = 0;
    cur_ir        = '0;
    exp_idx       = '0;
    reset         = 1'b1;
    dif.flush     = 1'b0;
    dif.ir_load   = 1'b0;
    dif.instr     = '0;
    dif.sel_i     = 1'b0;
    dif.sel_j     = 1'b0;
    dif.imm_oe    = 1'b0;
    dif.exec_done = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // reset state
    check("rst_ready", dif.ready, 1);
    check("rst_opcode", dif.opcode, 0);
    check("rst_index", dif.index, 0);
    check("rst_strobes", strobes(), 0);
    check("rst_illegal", dif.illegal, 0);
    check("rst_timeout", dif.timeout, 0);
    check("rst_imm", dif.imm_out, 0);

    // ADD then index selection
    do_instr(16'h0A45, 3, 1'b0);
    check("add_opcode", dif.opcode, 0);
    sel_step(1'b1, 1'b0);
    check("add_sel_i", dif.index, 41);
    sel_step(1'b0, 1'b1);
    check("add_sel_j", dif.index, 5);
    sel_step(1'b1, 1'b1);
    check("add_sel_both", dif.index, 41);
    sel_step(1'b0, 1'b0);

    // MOVI with immediate drive, then imm_oe in IDLE
    do_instr(16'h903F, 2, 1'b1);
    dif.imm_oe = 1'b1;
    tick();
    check("idle_bus_oe", dif.bus_oe, 0);
`ifdef DECODER_SIGN_EXT_IMM_EN
    check("movi_imm", dif.imm_out, 16'hFFFF);
`else
    check("movi_imm", dif.imm_out, 16'h003F);
`endif
    dif.imm_oe = 1'b0;

    // illegal and STORE
    do_instr(16'hD000, 1, 1'b0);
    do_instr(16'hF123, 1, 1'b0);
    do_instr(16'hC000, 4, 1'b0);

    // watchdog abort and completion on the last allowed cycle
    do_instr(16'h0000, TMO + 5, 1'b0);
    tick();
    check("tmo_one_cycle", dif.timeout, 0);
    do_instr(16'h1111, TMO, 1'b0);

    // flush during ISSUE
    do_instr(16'h0A45, 0, 1'b0);
    sel_step(1'b1, 1'b0);
    dif.ir_load = 1'b1;
    dif.instr   = 16'h2A45;
    tick();
    dif.ir_load = 1'b0;
    cur_ir      = 16'h2A45;
    tick();
    check("pre_flush_alu", dif.alu_str, 1);
    dif.ir_load = 1'b1;      // ignored while issuing
    dif.instr   = 16'h903F;
    tick();
    dif.ir_load = 1'b0;
    check("busy_load_opcode", dif.opcode, 2);
    check("busy_load_alu", dif.alu_str, 1);
    check("busy_load_mov", dif.mov_str, 0);
    dif.flush = 1'b1;
    tick();
    dif.flush = 1'b0;
    exp_idx   = '0;
    check("flush_strobes", strobes(), 0);
    check("flush_index", dif.index, 0);
    check("flush_opcode", dif.opcode, 2);
    check("flush_ready", dif.ready, 1);

    // flush and ir_load together: instruction dropped
    dif.flush   = 1'b1;
    dif.ir_load = 1'b1;
    dif.instr   = 16'h903F;
    tick();
    dif.flush   = 1'b0;
    dif.ir_load = 1'b0;
    check("flush_load_ready", dif.ready, 1);
    check("flush_load_opcode", dif.opcode, 2);
    tick();
    check("flush_load_nostr", strobes(), 0);

    // randomized instructions
    for (int n = 0; n < 40; n++) begin
      rins = 16'($urandom);
      do_instr(rins, int'($urandom_range(1, TMO + 2)), 1'($urandom));
      if (dif.timeout === 1'b1) tick();
      sel_step(1'($urandom), 1'($urandom));
    end

    // asynchronous reset mid-ISSUE
    do_instr(16'h0A45, 0, 1'b0);
    sel_step(1'b1, 1'b0);
    dif.ir_load = 1'b1;
    dif.instr   = 16'hB7FF;
    tick();
    dif.ir_load = 1'b0;
    tick();
    dif.imm_oe = 1'b1;
    check("pre_rst_ldst", dif.ldst_str, 1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_ready", dif.ready, 1);
    check("arst_strobes", strobes(), 0);
    check("arst_opcode", dif.opcode, 0);
    check("arst_index", dif.index, 0);
    check("arst_bus_oe", dif.bus_oe, 0);
    check("arst_imm", dif.imm_out, 0);
    check("arst_flags", {dif.illegal, dif.timeout}, 0);
    dif.imm_oe = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_decoder_seq.md
Name: instr_decoder_seq

Overview:
- Clocked, parametrised instruction decoder.
- Latches an instruction word on request and classifies its opcode into ALU / MOV / LOAD-STORE execution classes.
- Holds a level start strobe to the selected execution unit until that unit signals completion.
- Also provides registered operand-index selection, an extended immediate for bus drive, illegal-opcode detection and an execution watchdog.
- Sits between the fetch logic (instruction register load, flush on fetch) and the execution units / register-file index port.

Parameters:
- INSTR_W, 16, instruction word width.
- OPC_W, 4, opcode field width; opcode = instr[INSTR_W-1 -: OPC_W].
- IDX_W, 6, operand index width; field_i = instr[INSTR_W-OPC_W-1 -: IDX_W], field_j = instr[IDX_W-1:0].
- IMM_W, 6, immediate width; imm = instr[IMM_W-1:0].
- BUS_W, 16, data bus width.
- TIMEOUT, 0, max cycles in ISSUE before abort; 0 disables the watchdog.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous abort (fetch restart).
- ir_load  in  1  load request for instr.
- instr  in  INSTR_W  instruction word.
- ready  out  1  high when state==IDLE.
- sel_i  in  1  load index from field_i.
- sel_j  in  1  load index from field_j.
- imm_oe  in  1  request immediate drive.
- exec_done  in  1  completion from the active execution unit.
- opcode  out  OPC_W  latched opcode.
- index  out  IDX_W  registered operand index.
- alu_str  out  1  ALU class start (level).
- mov_str  out  1  MOV class start (level).
- ldst_str  out  1  LOAD/STORE class start (level).
- imm_out  out  BUS_W  extended immediate.
- bus_oe  out  1  tri-state enable for imm_out; the top level owns the tri-state buffer.
- illegal  out  1  one-cycle pulse on an undefined opcode.
- timeout  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset state: IDLE; ir_q=0; opcode=0; index=0; all strobes=0; illegal=0; timeout=0; bus_oe=0.
- Opcode map:
  - ADD 0, SUB 1, NOT 2, AND 3, OR 4, XOR 5, XNOR 6, ADDI 7, SUBI 8 -> ALU class.
  - MOVI 9, MOV 10 -> MOV class.
  - LOAD 11, STORE 12 -> LDST class.
  - 13..15 -> illegal.
  - Opcode values >= 13 are illegal for any OPC_W.
- FSM states: IDLE, DECODE, ISSUE.
  - IDLE: ir_load=1 -> ir_q<=instr, opcode<=instr opcode field, go to DECODE. ir_load in any other state is ignored (no queueing).
  - DECODE (1 cycle): illegal -> illegal pulses for 1 cycle, return to IDLE. Otherwise set exactly one class strobe, go to ISSUE.
  - ISSUE: strobe held. exec_done=1 -> return to IDLE; strobe is low from the next cycle.
  - Latency: ir_load edge to strobe high = 2 cycles.
- Watchdog (TIMEOUT>0):
  - Counter clears on entering ISSUE and increments each ISSUE cycle.
  - On reaching TIMEOUT without exec_done: timeout pulses 1 cycle, strobe drops, return to IDLE.
  - exec_done in the same cycle the count reaches TIMEOUT counts as completion; no timeout pulse.
- exec_done outside ISSUE is ignored.
- Index register:
  - sel_i=1 -> index<=ir_q field_i next cycle.
  - sel_j=1 -> index<=ir_q field_j next cycle.
  - Both asserted: sel_i wins.
  - Neither asserted: index holds.
  - Index selection is legal in any state and reads ir_q, not instr.
- Immediate:
  - imm_out is combinational from ir_q: zero-extended imm to BUS_W (see optional feature).
  - bus_oe = imm_oe & (state==ISSUE). imm_out is valid regardless of bus_oe.
- flush:
  - Synchronous, priority over every other input except reset.
  - Effect: state->IDLE, strobes=0, index=0, watchdog cleared. ir_q and opcode are retained.
  - flush and ir_load in the same cycle: flush wins, instruction dropped.
- Reset mid-ISSUE: all outputs return to reset values immediately (asynchronous).
- Elaboration check: OPC_W+2*IDX_W <= INSTR_W, IMM_W <= BUS_W.

Optional Feature:
- Macro: DECODER_SIGN_EXT_IMM_EN.
- Defined: imm_out is imm sign-extended from bit IMM_W-1.
- Undefined: imm_out is zero-extended.
- No other behaviour changes.

Decomposition:
- Shared package decoder_pkg:
  - opcode localparams (ADD..STORE).
  - class enum {CLS_ALU, CLS_MOV, CLS_LDST, CLS_ILLEGAL}.
  - state enum {IDLE, DECODE, ISSUE}.
  - function opcode_class(opcode).
- Sub-module: decoder_watchdog (counter plus TIMEOUT compare, emits expire). Natural because it is reusable by the execution units.

Test Plan:
- ADD: ir_load with instr=16'h0A45, then exec_done after 3 ISSUE cycles -> alu_str high 2 cycles after load, opcode=0, held until exec_done; ready returns high the cycle after; sel_i -> index=41, sel_j -> index=5, both together -> 41.
- MOVI: instr=16'h903F, imm_oe=1 in ISSUE -> mov_str=1, bus_oe=1, imm_out=16'h003F; with DECODER_SIGN_EXT_IMM_EN, imm_out=16'hFFFF; imm_oe=1 in IDLE -> bus_oe=0.
- Illegal: instr=16'hD000 -> illegal pulses exactly 1 cycle in DECODE, no strobe, ready after 2 cycles; also a STORE (16'hC000) -> ldst_str only.
- Watchdog: TIMEOUT=8, no exec_done -> timeout pulse at the 8th ISSUE cycle, alu_str drops, IDLE; exec_done on cycle 8 -> no timeout.
- flush: flush during ISSUE -> strobe low and index=0 next cycle, opcode retained; flush plus ir_load same cycle -> no DECODE; ir_load while in ISSUE -> ignored.
- Reset asserted asynchronously mid-ISSUE -> all outputs at reset values before the next clk edge.
